// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory read port, IR handshake to decode, branch redirect.
interface fetch_unit_if #(
   parameter int unsigned ADDR_W = 8
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_valid;
   logic [15:0]       imem_rdata;
   logic [15:0]       ir;
   logic [ADDR_W-1:0] ir_pc;
   logic              ir_valid;
   logic              ir_ready;
   logic              br_taken;
   logic [ADDR_W-1:0] br_target;

   modport master (
      output imem_req, imem_addr, ir, ir_pc, ir_valid,
      input  imem_valid, imem_rdata, ir_ready, br_taken, br_target
   );

   modport slave (
      input  imem_req, imem_addr, ir, ir_pc, ir_valid,
      output imem_valid, imem_rdata, ir_ready, br_taken, br_target
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem read, IR with valid/ready to decode,
// branch redirect that discards any wrong-path fetch.
module fetch_unit #(
   parameter int unsigned     ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic         CLK,
   input  logic         reset,
   input  logic         halt,
   fetch_unit_if.master bus
);
   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t            state;
   logic              flush;
   logic [ADDR_W-1:0] pc;
   logic [15:0]       ir_q;
   logic [ADDR_W-1:0] ir_pc_q;
   logic              ir_valid_q;

   assign bus.imem_req  = (state == S_REQ) && !halt && !bus.br_taken && !reset;
   assign bus.imem_addr = pc;
   assign bus.ir        = ir_q;
   assign bus.ir_pc     = ir_pc_q;
   assign bus.ir_valid  = ir_valid_q;

   always_ff @(posedge CLK) begin
      if (reset) begin
         state      <= S_REQ;
         flush      <= 1'b0;
         pc         <= RESET_PC;
         ir_q       <= 16'h0000;
         ir_pc_q    <= '0;
         ir_valid_q <= 1'b0;
      end else begin
         case (state)
            S_REQ: begin
               if (bus.br_taken) begin
                  pc <= bus.br_target;
               end else if (!halt) begin
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (bus.imem_valid) begin
                  if (!flush && !bus.br_taken) begin
                     ir_q       <= bus.imem_rdata;
                     ir_pc_q    <= pc;
                     pc         <= pc + ADDR_W'(1);
                     ir_valid_q <= 1'b1;
                     state      <= S_HOLD;
                  end else begin
                     // wrong-path response: drop it and refetch from the current pc
                     flush <= 1'b0;
                     if (bus.br_taken) pc <= bus.br_target;
                     state <= S_REQ;
                  end
               end else if (bus.br_taken) begin
                  // request still in flight; remember to discard its response
                  pc    <= bus.br_target;
                  flush <= 1'b1;
               end
            end
            S_HOLD: begin
               if (bus.br_taken) begin
                  pc         <= bus.br_target;
                  ir_valid_q <= 1'b0;
                  state      <= S_REQ;
               end else if (bus.ir_ready) begin
                  ir_valid_q <= 1'b0;
                  state      <= S_REQ;
               end
            end
            default: state <= S_REQ;
         endcase
      end
   end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 16-bit CPU, directly upstream of the opcode parser. It holds the program counter, issues one read per instruction to instruction memory, and latches the returned word into the instruction register (IR). It presents the IR to decode through a valid/ready handshake, and redirects the PC on taken branches, discarding any wrong-path fetch.

## Interface
- ADDR_W, 8, width of PC and instruction-memory address
- RESET_PC, 0, PC value loaded on reset
- CLK  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- halt  input  1  when high, no new memory request is issued
- imem_req  output  1  read request to instruction memory (one-cycle pulse)
- imem_addr  output  ADDR_W  read address; equals PC
- imem_valid  input  1  read data valid; arrives 1 or more cycles after imem_req
- imem_rdata  input  16  instruction word from memory
- ir  output  16  instruction register, feeds the parser opcode input
- ir_pc  output  ADDR_W  address the current IR was fetched from
- ir_valid  output  1  IR holds an instruction not yet accepted by decode
- ir_ready  input  1  decode accepts IR this cycle when ir_valid && ir_ready
- br_taken  input  1  one-cycle branch redirect from execute
- br_target  input  ADDR_W  new PC when br_taken

## Operation
- States: S_REQ, S_WAIT, S_HOLD. There is also an internal `flush` flag.
- Reset (synchronous) sets pc=RESET_PC, state=S_REQ, flush=0, ir=0, ir_pc=0, ir_valid=0. imem_req is 0 while reset is high.
- imem_req = (state==S_REQ) && !halt && !br_taken && !reset. This is combinational. imem_addr = pc at all times.
- S_REQ:
  - If br_taken: pc<=br_target, stay in S_REQ, no request issued.
  - Else if halt: stay in S_REQ.
  - Else: the request is issued; go to S_WAIT.
- S_WAIT:
  - imem_valid && !flush && !br_taken: ir<=imem_rdata, ir_pc<=pc, pc<=pc+1, ir_valid<=1, go to S_HOLD.
  - imem_valid && (flush || br_taken): drop the data, flush<=0, go to S_REQ. If br_taken, also pc<=br_target.
  - !imem_valid && br_taken: pc<=br_target, flush<=1, stay in S_WAIT.
- S_HOLD:
  - br_taken (has priority over ir_ready): pc<=br_target, ir_valid<=0, go to S_REQ. The IR word is wrong-path and is discarded.
  - ir_ready: ir_valid<=0, go to S_REQ.
  - Otherwise: hold ir, ir_pc and ir_valid stable.
- PC arithmetic: pc+1 is taken modulo 2^ADDR_W. The PC at 2^ADDR_W-1 wraps to 0 with no flag.
- imem_valid outside S_WAIT is ignored.
- At most one memory request is outstanding at any time.
- ir changes only on an accepted memory response. After handshake, ir keeps its last value, and only ir_valid drops.
- A repeated br_taken while flush=1 updates pc only; a single stale response is still dropped.

## Timing
- With 1-cycle memory latency, imem_req is at cycle n, imem_valid at n+1, and ir_valid rises at n+2.
- If ir_ready is high at n+2, the next imem_req is at n+3. Peak throughput is 1 instruction per 3 cycles.
- Each extra memory wait cycle adds one cycle to this loop. Each cycle ir_ready is low while ir_valid=1 also adds one cycle.
- br_taken at cycle m in S_HOLD or S_REQ: the request to br_target issues at m+1.
- br_taken in S_WAIT: the request to br_target issues on the cycle after the stale response arrives.
- Reset asserted in any state takes effect at the next edge. A memory response that arrives after reset is ignored, because state is S_REQ and imem_valid is ignored outside S_WAIT.
- In the first cycle after reset deasserts, imem_req=1 with imem_addr=RESET_PC, unless halt is high.

## Test plan
- Reset values: hold reset 3 cycles with imem_valid toggling -> ir=0, ir_pc=0, ir_valid=0, imem_req=0. The first cycle after release gives imem_req=1, imem_addr=0.
- Sequential fetch: memory returns 0x2000, 0x4401, 0x6C07 with 1-cycle latency, ir_ready=1 -> ir takes each word in order with ir_pc=0,1,2. Requests are 3 cycles apart.
- Backpressure: hold ir_ready=0 for 5 cycles with ir=0x4401 -> ir and ir_valid are stable and no imem_req is issued. The request to addr 2 issues the cycle after ir_ready rises.
- Branch in S_HOLD: br_taken with br_target=0x40 while ir_valid=1 and ir_ready=1 -> ir_valid drops and the next imem_addr=0x40. The held word is never handshaken.
- Branch in S_WAIT with 3-cycle memory latency: br_taken with br_target=0x10 -> the stale response is dropped with ir_valid staying 0. Then a request to 0x10 issues, and ir_pc=0x10 on the next valid IR.
- Wrap and halt: set PC to 0xFF via a branch, then fetch -> ir_pc=0xFF and the next imem_addr=0x00. Assert halt in S_REQ -> imem_req stays 0 until halt is released.
